// File: rtl/div_iter_unit.sv
// Iterative restoring divider for DIV/DIVU in the execute stage.
// Produces one quotient bit per cycle; busy stalls the pipeline while an operation is in flight.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // Handshake: start is honoured only in IDLE with cancel low; busy is high
  // from the cycle after acceptance until results are written; done pulses
  // for one cycle when quotient/remainder have just been updated.
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             div_zero;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;

  assign accept    = (state == IDLE) && start && !cancel;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign a_mag     = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_div && b[WIDTH-1]) ? -b : b;

  // Borrow bit of the trial subtraction doubles as the "remainder < divisor" flag.
  assign trial = {rem, dvd[WIDTH-1]} - {1'b0, dvs};

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = FIX;
        end
      end
      FIX: begin
        if (cancel) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd      <= a_mag;
            dvs      <= b_mag;
            sign_q   <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r   <= signed_div & a[WIDTH-1];
            div_zero <= (b == '0);
            rem      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (!cancel) begin
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
            end else begin
              rem <= {rem[WIDTH-2:0], dvd[WIDTH-1]};
            end
            // Dividend register fills with quotient bits as it shifts out.
            dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (!cancel) begin
            // Divide by zero keeps the all-ones quotient; the remainder fix-up
            // then reproduces the raw dividend.
            quotient  <= (sign_q && !div_zero) ? -dvd : dvd;
            remainder <= sign_r ? -rem : rem;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Bench for div_iter_unit: timeline/arithmetic reference model checked every cycle,
// directed cases with literal expectations, then a randomized stream.
module tb_div_iter_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_checks = 0;
  int n_errors = 0;

  // Model: k counts cycles since acceptance (0 = idle), results land at k==34.
  int           k = 0;
  logic [W-1:0] model_quot = '0;
  logic [W-1:0] model_rem = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];

  div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .cancel(cancel), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sx, sy, tq, tr;
    if (y == '0) begin
      q = '1;
      r = x;
    end else if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      tq = sx / sy;
      tr = sx % sy;
      q = tq[W-1:0];
      r = tr[W-1:0];
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] tq, tr;
    if (rst) begin
      k = 0;
      model_quot = '0;
      model_rem = '0;
      exp_q.delete();
      exp_r.delete();
    end else if (k == 0) begin
      if (start && !cancel) begin
        ref_div(a, b, signed_div, tq, tr);
        exp_q.push_back(tq);
        exp_r.push_back(tr);
        k = 1;
      end
    end else if (k == 34) begin
      k = 0;
    end else if (cancel) begin
      void'(exp_q.pop_front());
      void'(exp_r.pop_front());
      k = 0;
    end else if (k == 33) begin
      model_quot = exp_q.pop_front();
      model_rem = exp_r.pop_front();
      k = 34;
    end else begin
      k++;
    end
  end

  always @(negedge clk) begin
    check("busy", {31'b0, busy}, {31'b0, (k >= 1 && k <= 33)});
    check("done", {31'b0, done}, {31'b0, (k == 34)});
    check("quotient", quotient, model_quot);
    check("remainder", remainder, model_rem);
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sg, input logic [W-1:0] eq, input logic [W-1:0] er);
    int n;
    a = x; b = y; signed_div = sg; start = 1'b1;
    wait_cycle();
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      wait_cycle();
      n++;
    end
    check({name, "_latency"}, W'(n), 32'd34);
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    wait_cycle();
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(1, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [W-1:0] mq, mr;
    int done_cnt, done_at;

    // Pin the reference model against hand-computed values.
    ref_div(32'd100, 32'd7, 1'b0, mq, mr);
    check("model_100_7_q", mq, 32'd14);
    check("model_100_7_r", mr, 32'd2);
    ref_div(32'hFFFF_FF9C, 32'd7, 1'b1, mq, mr);
    check("model_m100_7_q", mq, 32'hFFFF_FFF2);
    check("model_m100_7_r", mr, 32'hFFFF_FFFE);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr);
    check("model_ovf_q", mq, 32'h8000_0000);
    check("model_ovf_r", mr, 32'd0);
    ref_div(32'd5, 32'd0, 1'b0, mq, mr);
    check("model_dz_q", mq, 32'hFFFF_FFFF);
    check("model_dz_r", mr, 32'd5);

    // Reset state.
    wait_cycle();
    wait_cycle();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    rst = 1'b0;
    wait_cycle();

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_op("sm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_op("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2);
    run_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    run_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);

    // Restarts while busy are ignored.
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    done_cnt = 0; done_at = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      wait_cycle();
      start = (cyc == 5 || cyc == 20);
      if (start) begin a = 32'd50; b = 32'd5; end
      if (done) begin done_cnt++; done_at = cyc; end
      if (cyc == 34) begin
        check("restart_q", quotient, 32'd333);
        check("restart_r", remainder, 32'd1);
      end
    end
    start = 1'b0;
    check("restart_done_cnt", W'(done_cnt), 32'd1);
    check("restart_done_at", W'(done_at), 32'd34);

    // Cancel mid-run, then a fresh operation.
    a = 32'd77; b = 32'd5; start = 1'b1;
    done_cnt = 0; done_at = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      wait_cycle();
      start = 1'b0;
      cancel = (cyc == 10);
      if (cyc == 11) begin
        check("cancel_busy", {31'b0, busy}, 32'd0);
        check("cancel_q_hold", quotient, 32'd333);
        check("cancel_r_hold", remainder, 32'd1);
      end
      if (cyc == 12) begin
        a = 32'd900; b = 32'd7; start = 1'b1;
      end
      if (done) begin done_cnt++; done_at = cyc; end
    end
    start = 1'b0;
    check("cancel_done_cnt", W'(done_cnt), 32'd1);
    check("cancel_done_at", W'(done_at), 32'd46);
    check("after_cancel_q", quotient, 32'd128);
    check("after_cancel_r", remainder, 32'd4);

    // Asynchronous reset mid-run.
    a = 32'd12345; b = 32'd10; start = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      wait_cycle();
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_q", quotient, 32'd0);
    check("arst_r", remainder, 32'd0);
    wait_cycle();
    rst = 1'b0;
    wait_cycle();
    wait_cycle();
    check("arst_idle_busy", {31'b0, busy}, 32'd0);

    // Randomized stream with stray starts and occasional cancels.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      start = ($urandom_range(0, 5) == 0);
      cancel = ($urandom_range(0, 199) == 0);
      signed_div = 1'($urandom_range(0, 1));
      a = rand_operand();
      b = rand_operand();
      wait_cycle();
    end
    start = 1'b0;
    cancel = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) wait_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle iterative 32-bit integer divider for the 5-stage MIPS pipeline.
- Serves DIV and DIVU; the quotient/remainder feed LO/HI.
- Sits in the execute stage. Its busy output is the divbusyE signal the hazard unit uses to stall F/D and bubble E.
- Operands are latched at start, because the issuing instruction is flushed from E on the next cycle.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is verified.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  divE: a divide instruction is in E with operands valid this cycle
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- a  input  WIDTH  dividend (forwarded srcaE)
- b  input  WIDTH  divisor (forwarded srcbE)
- cancel  input  1  exception flush: abort the current division
- busy  output  1  divbusyE: division in progress
- done  output  1  one-cycle pulse: quotient/remainder updated this cycle
- quotient  output  WIDTH  result for LO
- remainder  output  WIDTH  result for HI

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0; internal regs cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If start=1 and cancel=0 at the edge:
    - latch |a| and |b| (magnitudes when signed_div=1, raw values otherwise);
    - latch sign_q = a[31]^b[31] and sign_r = a[31] (both forced to 0 when unsigned);
    - latch div_zero = (b==0);
    - set partial remainder=0, counter=0; go to RUN.
  - start with cancel=1 is ignored.
- RUN: restoring division, one quotient bit per cycle, MSB first.
  - shift {rem,dvd} left by 1;
  - if rem >= |b|: rem -= |b|, new q bit = 1; else new q bit = 0;
  - counter++.
  - After WIDTH iterations (counter==WIDTH-1 at the edge), go to FIX.
- FIX:
  - quotient reg <= sign_q ? -q : q;
  - remainder reg <= sign_r ? -rem : rem;
  - go to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE. A start seen in DONE is ignored.
- busy=1 in RUN and FIX; 0 in IDLE and DONE.
- Timing: start sampled at the end of cycle 0. busy=1 in cycles 1..33; done=1 and busy=0 in cycle 34. New results are visible from cycle 34.
- quotient/remainder change only in FIX or on reset. Otherwise they hold, including across cancel.
- start while busy=1: ignored, with no effect on the running operation.
- cancel=1 in RUN or FIX: next edge returns to IDLE; busy=0; done stays 0; outputs keep their old values.
- Divide by zero: no trap. Results fall out of the restoring algorithm with sign fix-up skipped:
  - quotient = 0xFFFFFFFF;
  - remainder = a as latched (raw input value, not magnitude).
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. No flag.
- Arithmetic: internal remainder is WIDTH+1 bits so the compare/subtract cannot overflow. Negation is two's complement modulo 2^WIDTH. Remainder sign follows the dividend and |remainder| < |divisor|.

Test Plan:
1. Reset then unsigned 100/7:
   - after reset, all outputs are 0;
   - start, a=100, b=7, signed_div=0 in cycle 0;
   - busy=1 in cycles 1..33;
   - cycle 34: done=1, quotient=14, remainder=2, busy=0.
2. Signed divides:
   - -100/7 (a=0xFFFFFF9C): quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2);
   - 100/-7: quotient=-14, remainder=2.
3. Boundary cases:
   - DIVU 0xFFFFFFFF/1: quotient=0xFFFFFFFF, remainder=0;
   - DIV 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0;
   - DIVU 5/0: quotient=0xFFFFFFFF, remainder=5.
4. start pulsed again at cycles 5 and 20 with different operands: ignored. The first result is unchanged, and done pulses only once, at cycle 34.
5. cancel asserted at cycle 10:
   - cycle 11: busy=0; done never pulses; quotient/remainder keep the prior result;
   - a new start at cycle 12 completes correctly, with done at cycle 46.
6. Reset at cycle 15 mid-RUN: busy, done and outputs drop to 0 immediately (asynchronous), and the unit returns to IDLE.
